// File: rtl/ps2_porttransmitter.sv
// rtl/ps2_porttransmitter.sv - host-to-device PS/2 byte transmitter driving open-drain pull-low enables
// Optional watchdog abort on a silent device: define PS2_TX_TIMEOUT_EN.
module ps2_porttransmitter #(
    parameter int RTS_CYCLES = 10000
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_ack_err,
    output logic       tx_timeout_err
);
    localparam int RTS_W = $clog2(RTS_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_REL
    } state_t;

    state_t           state, state_next;
    logic [1:0]       c_sync, d_sync;
    logic [7:0]       filt;
    logic             f_clk, f_clk_next, fall_edge;
    logic [8:0]       b, b_next;
    logic [3:0]       n, n_next;
    logic [RTS_W-1:0] cnt, cnt_next;
    logic             ack_err, ack_err_next;
    logic             done, done_next;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]  wd, wd_next;
    logic             timeout_err, timeout_err_next;
`endif

    // Line conditioning resets to the idle-high bus level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            filt   <= '1;
            f_clk  <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], ps2c_in};
            d_sync <= {d_sync[0], ps2d_in};
            filt   <= {filt[6:0], c_sync[1]};
            f_clk  <= f_clk_next;
        end
    end

    always_comb begin
        f_clk_next = f_clk;
        if (&filt)
            f_clk_next = 1'b1;
        else if (~|filt)
            f_clk_next = 1'b0;
    end

    assign fall_edge = f_clk & ~f_clk_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            b       <= '0;
            n       <= '0;
            cnt     <= '0;
            ack_err <= 1'b0;
            done    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd          <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            b       <= b_next;
            n       <= n_next;
            cnt     <= cnt_next;
            ack_err <= ack_err_next;
            done    <= done_next;
`ifdef PS2_TX_TIMEOUT_EN
            wd          <= wd_next;
            timeout_err <= timeout_err_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        b_next       = b;
        n_next       = n;
        cnt_next     = cnt;
        ack_err_next = ack_err;
        done_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_ps2) begin
                    b_next       = {~^din, din};
                    ack_err_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = S_RTS;
                end
            end
            S_RTS: begin
                if (cnt == RTS_W'(RTS_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = S_START;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_START: begin
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                // Nine falling edges shift out d0..d7 then parity.
                if (fall_edge) begin
                    b_next = {1'b0, b[8:1]};
                    if (n == 4'd0)
                        state_next = S_STOP;
                    else
                        n_next = n - 1'b1;
                end
            end
            S_STOP: begin
                if (fall_edge) begin
                    ack_err_next = d_sync[1];
                    state_next   = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (f_clk && d_sync[1]) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog runs only while the device owns the clock; zero on entry to start and per edge.
        wd_next          = '0;
        timeout_err_next = timeout_err;
        if (state == S_IDLE && wr_ps2)
            timeout_err_next = 1'b0;
        if (state != S_IDLE && state != S_RTS) begin
            if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_next       = S_IDLE;
                timeout_err_next = 1'b1;
                done_next        = 1'b1;
                n_next           = '0;
            end else if (!fall_edge) begin
                wd_next = wd + 1'b1;
            end
        end
`endif
    end

    assign ps2c_drive_low = (state == S_RTS);
    assign ps2d_drive_low = (state == S_START) || (state == S_DATA && !b[0]);
    assign tx_idle        = (state == S_IDLE);
    assign tx_done_tick   = done;
    assign tx_ack_err     = ack_err;
`ifdef PS2_TX_TIMEOUT_EN
    assign tx_timeout_err = timeout_err;
`else
    assign tx_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_porttransmitter.sv
// tb/tb_ps2_porttransmitter.sv - scoreboard bench for ps2_porttransmitter with a PS/2 device model
module tb_ps2_porttransmitter;
    localparam int RTS  = 10000;
    localparam int TOUT = 5000;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_drive_low, ps2d_drive_low, tx_idle, tx_done_tick, tx_ack_err, tx_timeout_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    logic [10:0] exp_frame_q[$];
    logic        exp_ack_q[$];

    always #5 clk = ~clk;

    // Open-drain wired-AND of host pull-downs and device.
    assign ps2c_in = dev_clk & ~ps2c_drive_low;
    assign ps2d_in = dev_data & ~ps2d_drive_low;

    ps2_porttransmitter #(
        .RTS_CYCLES(RTS)
`ifdef PS2_TX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TOUT)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2c_in       (ps2c_in),
        .ps2d_in       (ps2d_in),
        .wr_ps2        (wr_ps2),
        .din           (din),
        .ps2c_drive_low(ps2c_drive_low),
        .ps2d_drive_low(ps2d_drive_low),
        .tx_idle       (tx_idle),
        .tx_done_tick  (tx_done_tick),
        .tx_ack_err    (tx_ack_err),
        .tx_timeout_err(tx_timeout_err)
    );

    always @(posedge clk) begin
        #1;
        if (tx_done_tick) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Device: sample start before clocking, then one bit after each rising edge; ack on the 11th clock.
    task automatic device(input int n_fall, input bit nack, output logic [10:0] seen, output int rts_len);
        int t;
        seen    = '0;
        rts_len = 0;
        t       = 0;
        while (!ps2c_drive_low && t < 100) begin @(negedge clk); t++; end
        while (ps2c_drive_low && t < RTS + 300) begin @(negedge clk); rts_len++; t++; end
        repeat (20) @(negedge clk);
        seen[0] = ps2d_in;
        for (int k = 1; k <= n_fall; k++) begin
            if (k == 11 && !nack) dev_data = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (5) @(negedge clk);
            if (k <= 10) seen[k] = ps2d_in;
            repeat (HALF - 15) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (n_done == d0 && t < 1000) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input bit nack, input bit poke);
        logic [10:0] seen;
        logic [10:0] e_frame;
        logic        e_ack;
        int          rl;
        int          d0;
        d0 = n_done;
        exp_frame_q.push_back({1'b1, ~^d, d, 1'b0});
        exp_ack_q.push_back(nack);
        fork
            device(11, nack, seen, rl);
            begin
                pulse_wr(d);
                check("ack_err_cleared", tx_ack_err, 1'b0);
                check("tx_idle_busy", tx_idle, 1'b0);
                if (poke) begin
                    repeat (RTS + 20 + 8 * HALF) @(negedge clk);
                    pulse_wr(8'h00);
                end
            end
        join
        check("rts_len", rl, RTS);
        wait_done(d0);
        e_frame = exp_frame_q.pop_front();
        e_ack   = exp_ack_q.pop_front();
        check("done_count", n_done - d0, 1);
        check("frame_bits", seen, e_frame);
        check("ack_err", tx_ack_err, e_ack);
        check("idle_after", tx_idle, 1'b1);
        check("drives_after", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
    endtask

    initial begin
        logic [10:0] seen;
        int          rl;
        int          d0;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_drives", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
        check("rst_idle", tx_idle, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_ack_err", tx_ack_err, 1'b0);
        check("rst_timeout_err", tx_timeout_err, 1'b0);

        // Reset held for three cycles in the middle of request-to-send.
        pulse_wr(8'hF4);
        repeat (100) @(negedge clk);
        check("rts_active", ps2c_drive_low, 1'b1);
        d0    = n_done;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("midrst_drives", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
        check("midrst_idle", tx_idle, 1'b1);
        repeat (20) @(negedge clk);
        check("midrst_no_done", n_done - d0, 0);

        frame(8'hF4, 1'b0, 1'b0);
        frame(8'h55, 1'b1, 1'b0);
        frame(8'hED, 1'b0, 1'b1);

        // Device stops clocking after four edges.
        d0 = n_done;
        fork
            device(4, 1'b0, seen, rl);
            pulse_wr(8'hF4);
        join
        check("stall_rts_len", rl, RTS);
        repeat (TOUT - 300) @(negedge clk);
        check("stall_busy_early", tx_idle, 1'b0);
        repeat (400) @(negedge clk);
`ifdef PS2_TX_TIMEOUT_EN
        check("timeout_err", tx_timeout_err, 1'b1);
        check("timeout_done", n_done - d0, 1);
        check("timeout_idle", tx_idle, 1'b1);
        check("timeout_drives", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
`else
        check("stall_idle", tx_idle, 1'b0);
        check("stall_no_done", n_done - d0, 0);
        check("stall_no_timeout", tx_timeout_err, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("stall_rst_idle", tx_idle, 1'b1);
        check("stall_rst_drives", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
